// File: rtl/amstrad_mem_pkg.sv
// Shared types and constants for the Amstrad memory-port arbiter.
package amstrad_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2,
        ST_DMA  = 2'd3
    } arb_state_e;

    // Requester IDs double as bit positions in the one-hot grant vector
    localparam int REQ_VID = 0;
    localparam int REQ_CPU = 1;
    localparam int REQ_DMA = 2;
    localparam int REQ_N   = 3;

    localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
        logic [7:0] b;
        if (hi) begin
            b = word[15:8];
        end else begin
            b = word[7:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/amstrad_mem_prio.sv
// Fixed-priority grant selector: video first, then a starved DMA, then CPU, then DMA.
module amstrad_mem_prio
    import amstrad_mem_pkg::*;
(
    input  logic             vid_req,
    input  logic             cpu_req,
    input  logic             dma_req,
    input  logic             starve_sat,
    output logic [REQ_N-1:0] gnt
);

    // One-hot winner selection
    always_comb begin
        gnt = 3'b000;
        if (vid_req) begin
            gnt[REQ_VID] = 1'b1;
        end else if (starve_sat && dma_req) begin
            gnt[REQ_DMA] = 1'b1;
        end else if (cpu_req) begin
            gnt[REQ_CPU] = 1'b1;
        end else if (dma_req) begin
            gnt[REQ_DMA] = 1'b1;
        end else begin
            gnt = 3'b000;
        end
    end

endmodule

// File: rtl/amstrad_mem_arbiter.sv
// Arbitrates the single 16-bit memory port between video, Z80 and Plus-ASIC DMA,
// one transaction at a time with a per-transaction timeout.
module amstrad_mem_arbiter
    import amstrad_mem_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [14:0]       vid_addr,
    output logic              vid_ack,
    output logic [15:0]       vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic [15:0]       dma_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int SV_W  = $clog2(STARVE_MAX + 1);
    // Abort fires on the edge where the counter would reach TIMEOUT
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [SV_W-1:0]  SV_MAX   = SV_W'(STARVE_MAX);

    arb_state_e       state_r, state_n;
    logic [TMR_W-1:0] timer_r;
    logic [SV_W-1:0]  starve_r;
    logic             cpu_we_r;
    logic             cpu_byte_r;
    logic [REQ_N-1:0] gnt_s;
    logic             ack_any_s;
    logic             grant_s;
    logic             complete_s;
    logic             abort_s;
    logic [15:0]      rd_word_s;

    assign ack_any_s = vid_ack | cpu_ack | dma_ack;

    amstrad_mem_prio u_prio (
        .vid_req    (vid_req),
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .starve_sat (starve_r == SV_MAX),
        .gnt        (gnt_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state; no grant while an ack is still on the wire, so IDLE lasts a cycle
    always_comb begin
        state_n    = state_r;
        grant_s    = 1'b0;
        complete_s = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!ack_any_s && (gnt_s != 3'b000)) begin
                    grant_s = 1'b1;
                    if (gnt_s[REQ_VID]) begin
                        state_n = ST_VID;
                    end else if (gnt_s[REQ_CPU]) begin
                        state_n = ST_CPU;
                    end else begin
                        state_n = ST_DMA;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_VID, ST_CPU, ST_DMA: begin
                if (mem_ack) begin
                    complete_s = 1'b1;
                    state_n    = ST_IDLE;
                end else if (timer_r == TMR_LAST) begin
                    abort_s = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Word returned to the requester: memory data, or the poison value on timeout
    always_comb begin
        rd_word_s = mem_rdata;
        if (abort_s) begin
            rd_word_s = TIMEOUT_DATA;
        end else begin
            rd_word_s = mem_rdata;
        end
    end

    // DMA anti-starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_r <= {SV_W{1'b0}};
        end else if (grant_s && (state_n == ST_DMA)) begin
            starve_r <= {SV_W{1'b0}};
        end else if (grant_s && (state_n == ST_CPU) && dma_req && (starve_r != SV_MAX)) begin
            starve_r <= starve_r + SV_W'(1);
        end
    end

    // Memory strobes, transaction timer, acks and returned data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r     <= {TMR_W{1'b0}};
            cpu_we_r    <= 1'b0;
            cpu_byte_r  <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_be      <= 2'b00;
            mem_wdata   <= 16'h0000;
            vid_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            vid_data    <= 16'h0000;
            cpu_rdata   <= 8'h00;
            dma_data    <= 16'h0000;
            timeout_err <= 1'b0;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (grant_s) begin
                timer_r <= {TMR_W{1'b0}};
                case (state_n)
                    ST_VID: begin
                        mem_addr <= {{(ADDR_W-15){1'b0}}, vid_addr};
                        mem_rd   <= 1'b1;
                        mem_wr   <= 1'b0;
                        mem_be   <= 2'b00;
                    end
                    ST_CPU: begin
                        mem_addr   <= {1'b0, cpu_addr[ADDR_W-1:1]};
                        mem_rd     <= ~cpu_we;
                        mem_wr     <= cpu_we;
                        mem_be     <= cpu_we ? (cpu_addr[0] ? 2'b10 : 2'b01) : 2'b00;
                        mem_wdata  <= {cpu_wdata, cpu_wdata};
                        cpu_we_r   <= cpu_we;
                        cpu_byte_r <= cpu_addr[0];
                    end
                    ST_DMA: begin
                        mem_addr <= dma_addr;
                        mem_rd   <= 1'b1;
                        mem_wr   <= 1'b0;
                        mem_be   <= 2'b00;
                    end
                    default: begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                    end
                endcase
            end else if (complete_s || abort_s) begin
                mem_rd <= 1'b0;
                mem_wr <= 1'b0;
                mem_be <= 2'b00;
                if (abort_s) begin
                    timeout_err <= 1'b1;
                end
                case (state_r)
                    ST_VID: begin
                        vid_ack  <= 1'b1;
                        vid_data <= rd_word_s;
                    end
                    ST_CPU: begin
                        cpu_ack <= 1'b1;
                        // Writes carry no read data, so the last read byte is kept
                        if (!cpu_we_r) begin
                            cpu_rdata <= sel_byte(rd_word_s, cpu_byte_r);
                        end
                    end
                    ST_DMA: begin
                        dma_ack  <= 1'b1;
                        dma_data <= rd_word_s;
                    end
                    default: begin
                        vid_ack <= 1'b0;
                    end
                endcase
            end else if (state_r != ST_IDLE) begin
                timer_r <= timer_r + TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Directed bench for amstrad_mem_arbiter: the bench plays the memory controller.
module tb_amstrad_mem_arbiter;

    localparam int ADDR_W = 23;

    logic              clk = 1'b0;
    logic              reset;
    logic              vid_req, vid_ack;
    logic [14:0]       vid_addr;
    logic [15:0]       vid_data;
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata, cpu_rdata;
    logic              dma_req, dma_ack;
    logic [ADDR_W-1:0] dma_addr;
    logic [15:0]       dma_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd, mem_wr, mem_ack;
    logic [1:0]        mem_be;
    logic [15:0]       mem_wdata, mem_rdata;
    logic              timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_vid, cnt_cpu, cnt_dma;

    amstrad_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4), .TIMEOUT(31)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_data(dma_data),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and tally ack pulses seen there
    task automatic step();
        @(negedge clk);
        if (vid_ack) cnt_vid++;
        if (cpu_ack) cnt_cpu++;
        if (dma_ack) cnt_dma++;
    endtask

    task automatic clr_cnt();
        cnt_vid = 0;
        cnt_cpu = 0;
        cnt_dma = 0;
    endtask

    // Wait for a strobe, snapshot it, hold it dly cycles, then answer with mem_ack
    task automatic serve(input string tag, input logic [15:0] rdata, input int dly,
                         output logic [ADDR_W-1:0] addr, output logic [1:0] rw,
                         output logic [1:0] be, output logic [15:0] wdata, output int waited);
        waited = 0;
        step();
        while (!(mem_rd || mem_wr) && waited < 8) begin
            step();
            waited++;
        end
        check({tag, "_grant"}, 32'(mem_rd | mem_wr), 32'd1);
        addr  = mem_addr;
        rw    = {mem_rd, mem_wr};
        be    = mem_be;
        wdata = mem_wdata;
        for (int d = 0; d < dly; d++) step();
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
    endtask

    logic [ADDR_W-1:0] a;
    logic [1:0]        rw, be;
    logic [15:0]       wd;
    int                w, cyc;

    initial begin
        reset = 1'b1;
        vid_req = 1'b0; vid_addr = 15'h0000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 23'h000000; cpu_wdata = 8'h00;
        dma_req = 1'b0; dma_addr = 23'h000000;
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        clr_cnt();
        step(); step();
        check("rst_strobes", 32'({mem_rd, mem_wr, mem_be}), 32'd0);
        check("rst_acks", 32'({vid_ack, cpu_ack, dma_ack, timeout_err}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'({cpu_rdata, mem_wdata}), 32'd0);
        reset = 1'b0;
        step();

        // CPU read of the odd byte at 0x000101
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000101;
        serve("cpu_rd", 16'hA55A, 2, a, rw, be, wd, w);
        cpu_req = 1'b0;
        check("cpu_rd_addr", 32'(a), 32'h000080);
        check("cpu_rd_rw", 32'(rw), 32'b10);
        check("cpu_rd_ack", 32'(cpu_ack), 32'd1);
        check("cpu_rd_data", 32'(cpu_rdata), 32'hA5);
        check("cpu_rd_strobe_drop", 32'(mem_rd), 32'd0);
        step(); step();
        check("cpu_rd_pulses", 32'(cnt_cpu), 32'd1);
        check("cpu_rd_noerr", 32'(timeout_err), 32'd0);

        // Video and CPU together: video first, one idle cycle, then CPU
        clr_cnt();
        vid_req = 1'b1; vid_addr = 15'h1234;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000200;
        serve("vid", 16'hBEEF, 0, a, rw, be, wd, w);
        vid_req = 1'b0;
        check("vid_addr", 32'(a), 32'h001234);
        check("vid_ack", 32'(vid_ack), 32'd1);
        check("vid_data", 32'(vid_data), 32'hBEEF);
        step();
        check("vid_idle_gap", 32'(mem_rd | mem_wr), 32'd0);
        serve("cpu_after_vid", 16'h1122, 0, a, rw, be, wd, w);
        cpu_req = 1'b0;
        check("cpu_after_vid_wait", 32'(w), 32'd0);
        check("cpu_after_vid_addr", 32'(a), 32'h000100);
        check("cpu_after_vid_data", 32'(cpu_rdata), 32'h22);
        step(); step();
        check("vid_cpu_pulses", 32'({cnt_vid[3:0], cnt_cpu[3:0]}), 32'h11);

        // DMA starvation: four CPU grants, then DMA, then CPU again
        clr_cnt();
        dma_req = 1'b1; dma_addr = 23'h400000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000010;
        for (int i = 0; i < 6; i++) begin
            serve($sformatf("starve%0d", i), 16'hC000 | 16'(i), 0, a, rw, be, wd, w);
            check($sformatf("starve_pick%0d", i), 32'(a), (i == 4) ? 32'h400000 : 32'h000008);
            check($sformatf("starve_ack%0d", i), 32'({cpu_ack, dma_ack}),
                  (i == 4) ? 32'b01 : 32'b10);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check("starve_dma_data", 32'(dma_data), 32'hC004);
        check("starve_cpu_data", 32'(cpu_rdata), 32'h05);
        step(); step();
        check("starve_pulses", 32'({cnt_cpu[3:0], cnt_dma[3:0]}), 32'h51);

        // CPU write of the even byte
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000200; cpu_wdata = 8'h3C;
        serve("cpu_wr", 16'h0000, 1, a, rw, be, wd, w);
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("cpu_wr_rw", 32'(rw), 32'b01);
        check("cpu_wr_be", 32'(be), 32'b01);
        check("cpu_wr_wdata", 32'(wd), 32'h3C3C);
        check("cpu_wr_addr", 32'(a), 32'h000100);
        check("cpu_wr_ack", 32'(cpu_ack), 32'd1);
        check("cpu_wr_rdata_kept", 32'(cpu_rdata), 32'h05);
        step(); step();

        // DMA answered in the very last cycle before the deadline: ack wins
        clr_cnt();
        dma_req = 1'b1; dma_addr = 23'h012345;
        cyc = 0;
        step();
        while (!mem_rd && cyc < 8) begin step(); cyc++; end
        check("dl_grant", 32'(mem_rd), 32'd1);
        for (int k = 0; k < 30; k++) step();
        check("dl_still_busy", 32'({mem_rd, cnt_dma[3:0]}), 32'h10);
        mem_ack = 1'b1; mem_rdata = 16'h600D;
        step();
        mem_ack = 1'b0; dma_req = 1'b0;
        check("dl_ack", 32'(dma_ack), 32'd1);
        check("dl_data", 32'(dma_data), 32'h600D);
        check("dl_noerr", 32'(timeout_err), 32'd0);
        step(); step();

        // DMA never answered: timeout after 31 cycles
        clr_cnt();
        dma_req = 1'b1; dma_addr = 23'h000777;
        cyc = 0;
        step();
        while (!mem_rd && cyc < 8) begin step(); cyc++; end
        check("to_grant", 32'(mem_rd), 32'd1);
        cyc = 0;
        while (!dma_ack && cyc < 40) begin step(); cyc++; end
        dma_req = 1'b0;
        check("to_cycles", 32'(cyc), 32'd31);
        check("to_data", 32'(dma_data), 32'hFFFF);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_strobe_drop", 32'(mem_rd), 32'd0);
        for (int k = 0; k < 5; k++) step();
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        check("to_pulses", 32'(cnt_dma), 32'd1);

        // Reset in the middle of a CPU read
        clr_cnt();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000040;
        step(); step();
        check("rst_mid_busy", 32'(mem_rd), 32'd1);
        #2 reset = 1'b1;
        #1 check("rst_mid_async_drop", 32'({mem_rd, mem_wr}), 32'd0);
        cpu_req = 1'b0; mem_ack = 1'b1;
        step(); step();
        mem_ack = 1'b0; reset = 1'b0;
        check("rst_mid_err_clr", 32'(timeout_err), 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step(); step();
        check("rst_mid_no_ack", 32'(cnt_vid + cnt_cpu + cnt_dma), 32'd0);
        check("idle_ack_ignored", 32'({mem_rd, mem_wr}), 32'd0);

        cpu_req = 1'b1; cpu_addr = 23'h000003;
        serve("post_rst", 16'h7E81, 0, a, rw, be, wd, w);
        cpu_req = 1'b0;
        check("post_rst_addr", 32'(a), 32'h000001);
        check("post_rst_data", 32'({cpu_ack, cpu_rdata}), 32'h17E);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
